// File: rtl/data_mem_responder_if.sv
// Data-memory port between the MEM stage and the multi-cycle responder.
// The master drives the request; the slave returns data, ack, busy and err.
interface data_mem_responder_if;
   logic        ce;
   logic        we;
   logic        memRr;
   logic [31:0] addr;
   logic [31:0] wtData;
   logic [3:0]  w_mask;
   logic [3:0]  r_mask;
   logic [31:0] rdData;
   logic        ack;
   logic        busy;
   logic        err;

   modport master (
      output ce, we, memRr, addr, wtData, w_mask, r_mask,
      input  rdData, ack, busy, err
   );

   modport slave (
      input  ce, we, memRr, addr, wtData, w_mask, r_mask,
      output rdData, ack, busy, err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: word RAM with byte lanes,
// programmable wait states, one-cycle ack/err and a stall (busy) flag.
module data_mem_responder #(
   parameter int DEPTH       = 1024,
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   data_mem_responder_if.slave bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]        state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] idx_q;
   logic              oor_q;
   logic              wr_q;
   logic [31:0]       wd_q;
   logic [3:0]        wm_q;
   logic [3:0]        rm_q;
   logic [31:0]       rd_q;
   logic              ack_q;
   logic              err_q;

   logic [31:0] mem [DEPTH];

   logic        req;
   logic        access;
   logic        do_write;
   logic [31:0] rd_word;

   // Byte offset bits are not used; lanes come from the masks.
   logic unused_addr_lsb;
   assign unused_addr_lsb = &{1'b0, bus.addr[1:0]};

   assign req      = bus.ce & (bus.we | bus.memRr);
   assign access   = (state == WAIT) && (cnt == 4'd0);
   assign do_write = access & wr_q & ~oor_q & ~rst;

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < 4; i++) begin
         if (rm_q[i]) rd_word[8*i +: 8] = mem[idx_q][8*i +: 8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx_q <= '0;
         oor_q <= 1'b0;
         wr_q  <= 1'b0;
         wd_q  <= '0;
         wm_q  <= '0;
         rm_q  <= '0;
         rd_q  <= '0;
         ack_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req) begin
                  idx_q <= bus.addr[ADDR_W+1:2];
                  oor_q <= |bus.addr[31:ADDR_W+2];
                  wr_q  <= bus.we;
                  wd_q  <= bus.wtData;
                  wm_q  <= bus.w_mask;
                  rm_q  <= bus.r_mask;
                  cnt   <= 4'(WAIT_CYCLES);
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  ack_q <= 1'b1;
                  err_q <= oor_q;
                  rd_q  <= (wr_q | oor_q) ? 32'd0 : rd_word;
                  state <= RESP;
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // RAM is left out of reset so it maps onto block memory.
   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int i = 0; i < 4; i++) begin
            if (wm_q[i]) mem[idx_q][8*i +: 8] <= wd_q[8*i +: 8];
         end
      end
   end

   assign bus.rdData = rd_q;
   assign bus.ack    = ack_q;
   assign bus.err    = err_q;
   assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: WAIT_CYCLES=2 and 0 instances,
// expected responses queued at issue and checked by per-port monitors.
module tb_data_mem_responder;

   typedef struct {
      logic [31:0] rd;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_mem_responder_if b0();
   data_mem_responder_if b1();

   data_mem_responder #(
      .DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(2)
   ) u0 (
      .clk(clk), .rst(rst), .bus(b0)
   );

   data_mem_responder #(
      .DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(0)
   ) u1 (
      .clk(clk), .rst(rst), .bus(b1)
   );

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && b0.ack === 1'b1) begin
         if (q0.size() == 0) begin
            check("u0_unexpected_ack", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q0.pop_front();
            check("u0_rdData", b0.rdData, e.rd);
            check("u0_err", {31'd0, b0.err}, {31'd0, e.err});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && b1.ack === 1'b1) begin
         if (q1.size() == 0) begin
            check("u1_unexpected_ack", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q1.pop_front();
            check("u1_rdData", b1.rdData, e.rd);
            check("u1_err", {31'd0, b1.err}, {31'd0, e.err});
         end
      end
   end

   // mode 0: normal, 1: second request while busy, 2: reset in WAIT
   task automatic req0(input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] wm, input logic [3:0] rm,
                       input logic [31:0] erd, input logic eerr,
                       input int mode);
      int k;
      int bn;
      logic got;
      @(negedge clk);
      b0.ce = 1'b1; b0.we = w; b0.memRr = r;
      b0.addr = a; b0.wtData = d;
      b0.w_mask = wm; b0.r_mask = rm;
      if (mode != 2) q0.push_back('{erd, eerr});
      check("busy_pre", {31'd0, b0.busy}, 32'd0);
      @(posedge clk);
      #1;
      check("busy_capture", {31'd0, b0.busy}, 32'd1);
      k = 0; bn = 0; got = 1'b0;
      for (int i = 1; i <= 20 && !got; i++) begin
         @(negedge clk);
         if (i == 1 && mode == 2) begin
            rst = 1'b1;
            b0.ce = 1'b0;
            #1;
            check("abort_busy", {31'd0, b0.busy}, 32'd0);
            check("abort_ack", {31'd0, b0.ack}, 32'd0);
            repeat (4) @(negedge clk);
            rst = 1'b0;
            repeat (6) @(negedge clk);
            return;
         end
         if (i == 1 && mode == 1) begin
            b0.we = 1'b1; b0.memRr = 1'b0;
            b0.wtData = ~d; b0.w_mask = 4'hF;
         end else begin
            b0.ce = 1'b0;
         end
         if (b0.busy) bn++;
         if (b0.ack) begin
            got = 1'b1;
            k = i;
         end
      end
      check("ack_seen", {31'd0, got}, 32'd1);
      check("latency", k, 4);
      check("busy_cycles", bn, 4);
      @(negedge clk);
      check("busy_post", {31'd0, b0.busy}, 32'd0);
      check("ack_pulse", {31'd0, b0.ack}, 32'd0);
   endtask

   task automatic req1(input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] erd);
      int k;
      @(negedge clk);
      b1.ce = 1'b1; b1.we = w; b1.memRr = r;
      b1.addr = a; b1.wtData = d;
      b1.w_mask = 4'hF; b1.r_mask = 4'hF;
      q1.push_back('{erd, 1'b0});
      k = 0;
      for (int i = 1; i <= 10 && k == 0; i++) begin
         @(negedge clk);
         b1.ce = 1'b0;
         if (b1.ack) k = i;
      end
      check("u1_latency", k, 2);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t0;
      int n;
      int at[2];
      b0.ce = 0; b0.we = 0; b0.memRr = 0; b0.addr = 0;
      b0.wtData = 0; b0.w_mask = 0; b0.r_mask = 0;
      b1.ce = 0; b1.we = 0; b1.memRr = 0; b1.addr = 0;
      b1.wtData = 0; b1.w_mask = 0; b1.r_mask = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", {31'd0, b0.busy}, 32'd0);
      check("rst_ack", {31'd0, b0.ack}, 32'd0);

      req0(1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 4'h0, 32'h0, 0, 0);
      req0(0, 1, 32'h10, 32'h0, 4'h0, 4'hF, 32'hDEADBEEF, 0, 0);
      req0(1, 0, 32'h10, 32'h00AA0000, 4'b0100, 4'h0, 32'h0, 0, 0);
      req0(0, 1, 32'h10, 32'h0, 4'h0, 4'hF, 32'hDEAABEEF, 0, 0);
      req0(0, 1, 32'h10, 32'h0, 4'h0, 4'b0011, 32'h0000BEEF, 0, 0);
      req0(1, 0, 32'h0, 32'h11223344, 4'hF, 4'h0, 32'h0, 0, 0);
      req0(0, 1, 32'h1000, 32'h0, 4'h0, 4'hF, 32'h0, 1, 0);
      req0(1, 0, 32'h1000, 32'hFFFFFFFF, 4'hF, 4'h0, 32'h0, 1, 0);
      req0(0, 1, 32'h0, 32'h0, 4'h0, 4'hF, 32'h11223344, 0, 0);
      req0(0, 1, 32'h10, 32'h0, 4'h0, 4'hF, 32'hDEAABEEF, 0, 0);
      req0(0, 1, 32'h10, 32'h0, 4'h0, 4'h0, 32'h0, 0, 0);

      req0(0, 1, 32'h10, 32'h0, 4'h0, 4'hF, 32'hDEAABEEF, 0, 0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_rdData", b0.rdData, 32'h0);
      check("arst_ack", {31'd0, b0.ack}, 32'd0);
      check("arst_err", {31'd0, b0.err}, 32'd0);
      check("arst_busy", {31'd0, b0.busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      req0(1, 0, 32'h20, 32'hAAAAAAAA, 4'hF, 4'h0, 32'h0, 0, 1);
      req0(0, 1, 32'h20, 32'h0, 4'h0, 4'hF, 32'hAAAAAAAA, 0, 0);

      req0(1, 0, 32'h30, 32'h12345678, 4'hF, 4'h0, 32'h0, 0, 0);
      req0(1, 0, 32'h30, 32'hCAFEF00D, 4'hF, 4'h0, 32'h0, 0, 2);
      req0(0, 1, 32'h30, 32'h0, 4'h0, 4'hF, 32'h12345678, 0, 0);

      req1(1, 0, 32'h44, 32'h77777777, 32'h0);
      req1(0, 1, 32'h44, 32'h0, 32'h77777777);
      @(negedge clk);
      t0 = cyc;
      b1.ce = 1'b1; b1.we = 1'b1; b1.memRr = 1'b1;
      b1.addr = 32'h40; b1.wtData = 32'h0BADF00D;
      b1.w_mask = 4'hF; b1.r_mask = 4'hF;
      q1.push_back('{32'h0, 1'b0});
      q1.push_back('{32'h0, 1'b0});
      n = 0;
      for (int i = 1; i <= 20 && n < 2; i++) begin
         @(negedge clk);
         if (b1.ack) begin
            at[n] = cyc;
            n++;
            if (n == 2) b1.ce = 1'b0;
         end
      end
      b1.ce = 1'b0;
      check("b2b_acks", n, 2);
      check("b2b_first", at[0] - t0, 2);
      check("b2b_spacing", at[1] - at[0], 3);
      @(negedge clk);
      req1(0, 1, 32'h40, 32'h0, 32'h0BADF00D);

      repeat (6) @(negedge clk);
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
